// File: rtl/boot_seq_arb.sv
// rtl/boot_seq_arb.sv - boot ROM-to-RAM copy sequencer and CPU/SPI RAM round-robin arbiter
// Optional macro BOOT_PATCH_EN: loads patch_word into ROM slot 7 before each copy.
module boot_seq_arb #(
    parameter int AW        = 12,
    parameter int ROM_WORDS = 8,
    parameter int RAM_BASE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reboot,
`ifdef BOOT_PATCH_EN
    input  logic [15:0]   patch_word,
`endif
    output logic          rom_cs,
    output logic          rom_we,
    output logic [3:0]    rom_addr,
    output logic [15:0]   rom_din,
    input  logic [15:0]   rom_dout,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    input  logic [15:0]   ram_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic [15:0]   cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [15:0]   ext_wdata,
    output logic          ext_gnt,
    output logic [15:0]   ext_rdata,
    output logic          cpu_rst_n,
    output logic          boot_done
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_PATCH = 3'd1,
        S_RD    = 3'd2,
        S_WR    = 3'd3,
        S_RUN   = 3'd4
    } state_t;

`ifdef BOOT_PATCH_EN
    localparam state_t S_BOOT = S_PATCH;
`else
    localparam state_t S_BOOT = S_RD;
`endif

    localparam logic [3:0]    LAST_IDX = 4'(ROM_WORDS - 1);
    localparam logic [AW-1:0] BASE     = AW'(RAM_BASE);

    state_t      state;
    state_t      next_state;
    logic [3:0]  idx;
    logic [15:0] cap;
    logic        ext_turn;
    logic        arb_on;
    logic        g_cpu;
    logic        g_ext;

    // Arbitration is live only in RUN and suppressed in the reboot cycle.
    assign arb_on = (state == S_RUN) && !reboot;
    assign g_cpu  = arb_on && cpu_req && (!ext_req || !ext_turn);
    assign g_ext  = arb_on && ext_req && (!cpu_req || ext_turn);

    assign cpu_gnt   = g_cpu;
    assign ext_gnt   = g_ext;
    assign cpu_rdata = ram_rdata;
    assign ext_rdata = ram_rdata;
    assign boot_done = (state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_BOOT;
            S_PATCH: next_state = S_RD;
            S_RD:    next_state = S_WR;
            S_WR:    next_state = (idx == LAST_IDX) ? S_RUN : S_RD;
            S_RUN:   next_state = reboot ? S_BOOT : S_RUN;
            default: next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= 4'd0;
            cap       <= 16'd0;
            ext_turn  <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= (next_state == S_RUN);
            if (state == S_RD) begin
                cap <= rom_dout;
            end
            if (state == S_WR && idx != LAST_IDX) begin
                idx <= idx + 4'd1;
            end
            if (state == S_RUN && reboot) begin
                idx      <= 4'd0;
                ext_turn <= 1'b0;
            end else if (g_cpu) begin
                ext_turn <= 1'b1;
            end else if (g_ext) begin
                ext_turn <= 1'b0;
            end
        end
    end

    always_comb begin
        rom_cs    = 1'b0;
        rom_we    = 1'b0;
        rom_addr  = 4'd0;
        rom_din   = 16'd0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 16'd0;
        case (state)
`ifdef BOOT_PATCH_EN
            S_PATCH: begin
                rom_cs   = 1'b1;
                rom_we   = 1'b1;
                rom_addr = 4'd7;
                rom_din  = patch_word;
            end
`endif
            S_RD: begin
                rom_cs   = 1'b1;
                rom_addr = idx;
            end
            S_WR: begin
                ram_cs    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = BASE + AW'(idx);
                ram_wdata = cap;
            end
            S_RUN: begin
                if (g_cpu) begin
                    ram_cs    = 1'b1;
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                end else if (g_ext) begin
                    ram_cs    = 1'b1;
                    ram_we    = ext_we;
                    ram_addr  = ext_addr;
                    ram_wdata = ext_wdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_boot_seq_arb.sv
// tb/tb_boot_seq_arb.sv - self-checking bench for boot_seq_arb with ROM/RAM models
module tb_boot_seq_arb;

    localparam int AW = 12;
`ifdef BOOT_PATCH_EN
    localparam int BOOT_CYC = 17;
`else
    localparam int BOOT_CYC = 16;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          reboot = 1'b0;
`ifdef BOOT_PATCH_EN
    logic [15:0]   patch_word = 16'h1234;
`endif
    logic          rom_cs, rom_we;
    logic [3:0]    rom_addr;
    logic [15:0]   rom_din, rom_dout;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata, ram_rdata;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_wdata = 16'h1111;
    logic          cpu_gnt;
    logic [15:0]   cpu_rdata;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [15:0]   ext_wdata = 16'h2222;
    logic          ext_gnt;
    logic [15:0]   ext_rdata;
    logic          cpu_rst_n, boot_done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    boot_seq_arb #(.AW(AW), .ROM_WORDS(8), .RAM_BASE(0)) dut (
        .clk(clk), .rst(rst), .reboot(reboot),
`ifdef BOOT_PATCH_EN
        .patch_word(patch_word),
`endif
        .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_din(rom_din), .rom_dout(rom_dout),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .cpu_rst_n(cpu_rst_n), .boot_done(boot_done)
    );

    // ROM: fixed preset with a writable slot 7
    logic [15:0] rom_preset [0:15];
    logic [15:0] slot7_q = 16'h0000;
    logic        slot7_wr = 1'b0;
    assign rom_dout = (slot7_wr && rom_addr == 4'd7) ? slot7_q : rom_preset[rom_addr];
    always @(posedge clk) begin
        if (rom_cs && rom_we && rom_addr == 4'd7) begin
            slot7_q  <= rom_din;
            slot7_wr <= 1'b1;
        end
    end

    logic [15:0] ram [0:(1<<AW)-1];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram[ram_addr] <= ram_wdata;
    end

    logic [15:0] exp_ram [0:7];

    typedef struct {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic          ereq;
        logic          ewe;
        logic [AW-1:0] eaddr;
        logic          cg;
        logic          eg;
        logic          cs;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wd;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_boot(output int cyc, output int gnts);
        cyc = 0;
        gnts = 0;
        while (!boot_done && cyc < 40) begin
            @(negedge clk);
            if (cpu_gnt || ext_gnt) gnts++;
            step();
            cyc++;
        end
    endtask

    task automatic chk_first_boot_cycle(input string nm);
`ifdef BOOT_PATCH_EN
        chk({nm, "_patch_ctl"}, {rom_cs, rom_we, rom_addr}, {1'b1, 1'b1, 4'd7});
        chk({nm, "_patch_din"}, rom_din, 16'h1234);
`else
        chk({nm, "_rd_ctl"}, {rom_cs, rom_we, rom_addr}, {1'b1, 1'b0, 4'd0});
        chk({nm, "_rd_din"}, rom_din, 16'h0000);
`endif
    endtask

    task automatic chk_ram(input string nm);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_ram%0d", nm, i), ram[i], exp_ram[i]);
    endtask

    initial begin
        int cyc, gnts, n;
        logic [15:0] preset [0:7];

        preset = '{16'hF200, 16'h4000, 16'hF800, 16'hF400, 16'hB007, 16'h6007, 16'h4000, 16'h000F};
        for (int i = 0; i < 16; i++) rom_preset[i] = (i < 8) ? preset[i] : 16'hEEEE;
        for (int i = 0; i < 8; i++) exp_ram[i] = preset[i];
`ifdef BOOT_PATCH_EN
        exp_ram[7] = 16'h1234;
`endif

        tv[0] = '{1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h030, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 16'h1111};
        tv[1] = '{1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h030, 1'b0, 1'b1, 1'b1, 1'b1, 12'h030, 16'h2222};
        tv[2] = '{1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h030, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 16'h1111};
        tv[3] = '{1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h030, 1'b0, 1'b1, 1'b1, 1'b1, 12'h030, 16'h2222};
        tv[4] = '{1'b0, 1'b0, 12'h020, 1'b0, 1'b0, 12'h030, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000};
        tv[5] = '{1'b0, 1'b0, 12'h020, 1'b1, 1'b0, 12'h010, 1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 16'h0000};
        tv[6] = '{1'b1, 1'b1, 12'h003, 1'b1, 1'b0, 12'h031, 1'b1, 1'b0, 1'b1, 1'b1, 12'h003, 16'h1111};
        tv[7] = '{1'b1, 1'b0, 12'h020, 1'b0, 1'b0, 12'h031, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0000};
        tv[8] = '{1'b1, 1'b1, 12'h022, 1'b1, 1'b1, 12'h031, 1'b0, 1'b1, 1'b1, 1'b1, 12'h031, 16'h2222};
        tv[9] = '{1'b1, 1'b1, 12'h022, 1'b1, 1'b1, 12'h031, 1'b1, 1'b0, 1'b1, 1'b1, 12'h022, 16'h1111};

        // Reset state
        step();
        step();
        chk("reset_ctl", {rom_cs, rom_we, ram_cs, ram_we, cpu_gnt, ext_gnt, cpu_rst_n, boot_done}, 8'h00);
        chk("reset_rom_bus", {rom_addr, rom_din}, 20'h0);

        // Reset pulled mid-copy at word 3
        rst = 1'b1;
        step();
        n = 0;
        while (!(rom_cs && !rom_we && rom_addr == 4'd3) && n < 40) begin
            step();
            n++;
        end
        chk("midcopy_reached_word3", {rom_cs, rom_addr}, {1'b1, 4'd3});
        rst = 1'b0;
        #1;
        chk("midcopy_rst_ctl", {rom_cs, rom_we, ram_cs, ram_we, cpu_rst_n, boot_done}, 6'h00);
        chk("midcopy_rst_addr", rom_addr, 4'd0);
        step();
        step();
        rst = 1'b1;
        ext_req = 1'b1;
        ext_we = 1'b1;
        ext_addr = 12'h010;
        ext_wdata = 16'hA5A5;
        step();
        chk_first_boot_cycle("boot1_first");
        chk("boot1_cpu_rst_low", cpu_rst_n, 1'b0);

        // Full copy; ext request held throughout must not be granted
        run_boot(cyc, gnts);
        chk("boot1_cycles", cyc, BOOT_CYC);
        chk("boot1_no_gnt_during_copy", gnts, 0);
        chk("boot1_cpu_rst_n", cpu_rst_n, 1'b1);
        @(negedge clk);
        chk("run1_ext_gnt", {cpu_gnt, ext_gnt, ram_cs, ram_we}, 4'b0111);
        chk("run1_ext_addr", ram_addr, 12'h010);
        chk("run1_ext_wdata", ram_wdata, 16'hA5A5);
        step();
        ext_req = 1'b0;
        ext_wdata = 16'h2222;
        chk("ram_010", ram[12'h010], 16'hA5A5);
        chk_ram("boot1");

        // Arbitration vectors
        for (int k = 0; k < 10; k++) begin
            cpu_req = tv[k].creq;
            cpu_we = tv[k].cwe;
            cpu_addr = tv[k].caddr;
            ext_req = tv[k].ereq;
            ext_we = tv[k].ewe;
            ext_addr = tv[k].eaddr;
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", k), {cpu_gnt, ext_gnt, ram_cs}, {tv[k].cg, tv[k].eg, tv[k].cs});
            if (tv[k].cs) begin
                chk($sformatf("tv%0d_addr_we", k), {ram_we, ram_addr}, {tv[k].we, tv[k].addr});
                if (tv[k].we) chk($sformatf("tv%0d_wdata", k), ram_wdata, tv[k].wd);
            end
            step();
        end
        chk("tv_ram_020", ram[12'h020], 16'h1111);
        chk("tv_ram_030", ram[12'h030], 16'h2222);
        chk("tv_ram_003", ram[12'h003], 16'h1111);

        // CPU read passthrough
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 12'h010;
        ext_req = 1'b0;
        @(negedge clk);
        chk("read_gnt", {cpu_gnt, ram_cs, ram_we}, 3'b110);
        chk("read_rdata", {cpu_rdata, ext_rdata}, {16'hA5A5, 16'hA5A5});
        step();

        // Reboot with cpu_req held
        cpu_addr = 12'h040;
        reboot = 1'b1;
        @(negedge clk);
        chk("reboot_no_gnt", {cpu_gnt, ext_gnt, ram_cs}, 3'b000);
        step();
        reboot = 1'b0;
        chk("reboot_cpu_rst", {cpu_rst_n, boot_done}, 2'b00);
        chk_first_boot_cycle("boot2_first");
        run_boot(cyc, gnts);
        chk("boot2_cycles", cyc, BOOT_CYC);
        chk("boot2_no_gnt_during_copy", gnts, 0);
        @(negedge clk);
        chk("run2_cpu_gnt", {cpu_gnt, ext_gnt, ram_cs, ram_addr}, {3'b101, 12'h040});
        step();
        cpu_req = 1'b0;
        chk_ram("boot2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_seq_arb.md
Name: boot_seq_arb

Overview:
- Boot sequencer and RAM-bus arbiter placed between the 16-word boot ROM, main RAM, the CPU and the SPI loader port.
- After reset it holds the CPU in reset and copies ROM words 0..ROM_WORDS-1 into RAM starting at RAM_BASE.
- It then releases the CPU and round-robin arbitrates single-cycle RAM accesses between the CPU and the external (SPI) master.

Parameters:
AW, 12, RAM address width.
ROM_WORDS, 8, number of ROM words copied (1..16).
RAM_BASE, 0, RAM address receiving ROM word 0.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-low.
reboot  in  1  single-cycle pulse; restarts the boot copy.
rom_cs  out  1  ROM chip select.
rom_we  out  1  ROM write enable.
rom_addr  out  4  ROM word address.
rom_din  out  16  ROM write data.
rom_dout  in  16  ROM read data, valid in the same cycle as rom_cs & ~rom_we.
ram_cs  out  1  RAM select.
ram_we  out  1  RAM write enable.
ram_addr  out  AW  RAM address.
ram_wdata  out  16  RAM write data.
ram_rdata  in  16  RAM read data.
cpu_req / cpu_we  in  1 / 1  CPU access request and direction.
cpu_addr / cpu_wdata  in  AW / 16  CPU address and write data.
cpu_gnt  out  1  CPU access performed this cycle.
cpu_rdata  out  16  equals ram_rdata.
ext_req / ext_we  in  1 / 1  SPI-master request and direction.
ext_addr / ext_wdata  in  AW / 16  SPI-master address and write data.
ext_gnt  out  1  SPI-master access performed this cycle.
ext_rdata  out  16  equals ram_rdata.
cpu_rst_n  out  1  CPU reset, active-low, registered.
boot_done  out  1  high in RUN.

Behaviour:
- Reset values: all outputs 0 (cpu_rst_n=0, boot_done=0); state RESET; word counter idx=0; rr pointer=CPU-first; capture register 0.
- FSM states: RESET, [PATCH], RD, WR, RUN.
- RESET -> RD on the first clock after rst deasserts; PATCH is entered instead when BOOT_PATCH_EN is defined.
- RD (1 cycle):
  - Drives rom_cs=1, rom_we=0, rom_addr=idx.
  - Captures rom_dout into a 16-bit register on the clock edge.
- WR (1 cycle):
  - Drives ram_cs=1, ram_we=1, ram_addr=RAM_BASE+idx (truncated to AW, wraps), ram_wdata=captured word.
  - If idx==ROM_WORDS-1, goes to RUN; otherwise idx+1 and back to RD.
- Copy takes exactly 2*ROM_WORDS cycles.
- On entering RUN, cpu_rst_n and boot_done go high on the same edge.
- RD/WR/PATCH: cpu_gnt=ext_gnt=0; requests are ignored and must be held by the requesters.
- RUN arbitration, combinational within the cycle:
  - Only one request: that requester is granted.
  - Both requesting: the requester not granted last is granted; the pointer updates on the clock edge after every grant.
  - Granted requester's we/addr/wdata drive ram_*, and ram_cs=1.
  - No request: ram_cs=0.
  - One grant max per cycle; a requester keeps req high until it sees gnt.
- reboot=1 in RUN:
  - No grant that cycle.
  - Next edge: cpu_rst_n=0, boot_done=0, idx=0, rr pointer reset, state RD (PATCH when the feature is enabled).
  - reboot is ignored outside RUN.
- Reset assertion mid-copy or mid-RUN: immediate asynchronous return to reset values; the copy restarts from word 0 after release.
- rom_din=0 and rom_we=0 in every state except PATCH.

Optional Feature:
Macro BOOT_PATCH_EN.
- Defined:
  - Adds input port patch_word[15:0].
  - PATCH state (1 cycle) precedes the first RD. It drives rom_cs=1, rom_we=1, rom_addr=7, rom_din=patch_word, so the writable ROM slot 7 is loaded before copying.
  - Copy length is +1 cycle.
- Undefined:
  - No PATCH state and no patch_word port.
  - rom_we is tied 0, and the ROM's reset contents are copied as-is.

Test Plan:
- Reset release, ROM_WORDS=8, ROM preset F200,4000,F800,F400,B007,6007,4000,000F -> RAM[0..7] holds these values; cpu_rst_n and boot_done rise exactly 16 cycles after the first post-reset edge (17 with BOOT_PATCH_EN).
- cpu_req and ext_req both held high in RUN for 4 cycles -> grants alternate CPU, EXT, CPU, EXT; one ram_cs per cycle.
- ext_req write addr 0x010 data 0xA5A5 issued during the copy -> no ext_gnt until RUN, then granted on the first RUN cycle; RAM[0x010]=0xA5A5.
- rst pulled low at copy word 3, then released -> outputs return to 0; the copy restarts at rom_addr 0 and RAM[0..7] is correct afterwards.
- reboot pulse in RUN with cpu_req high -> no cpu_gnt that cycle; cpu_rst_n=0 next cycle; a full recopy follows.
- BOOT_PATCH_EN with patch_word=0x1234 -> the first post-reset cycle writes ROM addr 7; RAM[7]=0x1234 after boot.
